datapath_exec: RTL and testbench
================================

Name: datapath_exec

Overview:
- Register-transfer datapath that executes the 32-bit control word issued each cycle by the microprogrammed control unit.
- Holds PC, MAR, MBR, IR, BR, ACC, MR and the ALU, and drives the memory port.
- Returns the opcode (data_to_cu) and status flags (flags) to the control unit, closing the CU↔datapath loop.
- Memory word format: [15:8] opcode, [7:0] operand address.

Parameters:
DATA_W, 16, width of MBR/BR/ACC/MR/memory word
ADDR_W, 8, width of PC/MAR/memory address
PC_RESET, 0, PC value after reset

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-low reset
control_signal  input  32  one control bit per micro-operation (bit map below)
mem_rdata  input  DATA_W  memory read data; asynchronous read of mem_addr, valid same cycle
mem_addr  output  ADDR_W  equals MAR
mem_wdata  output  DATA_W  equals MBR
mem_we  output  1  equals control_signal[12]
mem_re  output  1  control_signal[0] | control_signal[5]
data_to_cu  output  8  latched opcode for CU dispatch
flags  output  8  [0]Z [1]N [2]C [3]V [7]op_err sticky, [6:4]=0
pc_out  output  ADDR_W  current PC
acc_out  output  DATA_W  current ACC

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst). Reset is sampled only on a rising edge of clk.
- Reset (rst=0 at edge):
  - PC=PC_RESET; all other registers, data_to_cu and flags = 0.
  - Reset wins over any control bits in the same cycle, including mid-instruction.
- Register semantics: every transfer reads pre-edge values. Example: mbr2br|memory2mbr in the same cycle loads BR with the old MBR.
- Bit map and effects:
  - 0 mar2memory: mem_re only.
  - 1 pc2mbr: MBR<={0,PC}.
  - 2 pc2mar: MAR<=PC.
  - 3 mbr2pc: PC<=MBR[7:0].
  - 4 mbr2ir: IR<=MBR[15:8].
  - 5 memory2mbr: MBR<=mem_rdata.
  - 6 mbr2br: BR<=MBR.
  - 8 mbr2mar: MAR<=MBR[7:0].
  - 10 mbr2acc: ACC<=MBR.
  - 11 acc2mbr: MBR<=ACC.
  - 12 mbr2memory: mem_we.
  - 13 ir2cu: data_to_cu<=IR.
  - 15 mr2mbr: MBR<=MR.
  - 16 alu2mbr: MBR<=RES, where RES is the last ALU result register.
  - 20 pc_plus1: PC<=PC+1, wrapping 255→0.
  - 21 acc_clear: ACC<=0.
  - 22..31 ALU ops: add, sub, and, or, not, lsl, lsr, mpy, asl, asr.
  - Bits 7, 9, 14, 17–19 are ignored (CU-internal or enable-only).
- Write priorities when sources collide:
  - MBR: memory2mbr > alu2mbr > mr2mbr > acc2mbr > pc2mbr.
  - MAR: mbr2mar > pc2mar.
  - PC: mbr2pc > pc_plus1.
  - ACC: acc_clear > ALU op > mbr2acc.
- ALU (one cycle; result written to ACC and RES at the edge; operands are pre-edge ACC and BR; shift amount = BR[3:0]):
  - add: {C,ACC}=ACC+BR. V = signed overflow.
  - sub: ACC=ACC−BR. C=1 iff ACC≥BR unsigned. V = signed overflow.
  - and/or: bitwise. not: ~ACC, BR ignored. C and V cleared for all three.
  - lsl/lsr: logical shift. C = last bit shifted out (0 if amount=0). V=0.
  - asl: as lsl; V=1 if the sign bit changes at any shift step.
  - asr: sign-filling shift. C = last bit out. V=0.
  - mpy: signed 16×16. MR=product[31:16], ACC=RES=product[15:0]. C=0. V=1 iff the product does not fit in signed 16 bits.
- Flags:
  - Z and N are computed from the new ACC.
  - Flags update only on a valid ALU op; they hold otherwise, including on acc_clear and mbr2acc.
- Illegal combination: more than one of bits 22–31 set in a cycle.
  - ACC, RES, MR and Z/N/C/V are unchanged.
  - flags[7] is set and remains set until reset.
  - Non-ALU transfers in that cycle still execute.
- control_signal=0: all state holds; mem_we=0.

Test Plan:
- Reset then fetch: mem[0]=16'h0305; apply memory2mbr, then mbr2ir, then ir2cu → MBR=16'h0305, IR=8'h03, data_to_cu=8'h03.
- LOAD: ACC=5, MBR=16'h0107, mem[7]=16'h0009; apply mbr2mar|pc_plus1, memory2mbr, mbr2br|acc_clear, addition → ACC=9, PC+1, Z=0, N=0.
- Arithmetic edges:
  - ACC=16'h7FFF, BR=1, add → ACC=16'h8000, N=1, V=1, C=0.
  - ACC=3, BR=5, sub → ACC=16'hFFFE, C=0, N=1.
  - ACC=16'h0100, BR=16'h0100, mpy → MR=16'h0001, ACC=0, Z=1, V=1.
- Shifts:
  - ACC=16'h8001, BR=1, asr → ACC=16'hC000, C=1.
  - Same operands, lsr → ACC=16'h4000.
- STORE and collisions:
  - ACC=16'hABCD, MAR=16 (decimal); acc2mbr then mbr2memory → mem_we=1 for exactly one cycle, mem_addr=16, mem_wdata=16'hABCD.
  - memory2mbr|acc2mbr together → MBR=mem_rdata.
  - mbr2pc|pc_plus1 with PC=255, MBR[7:0]=8'h20 → PC=8'h20.
  - PC=255 with pc_plus1 alone → PC=0.
- Illegal/reset: addition|subtraction → ACC unchanged, flags[7]=1 until reset. rst=0 asserted mid-LOAD sequence → all registers 0 and PC=PC_RESET after one edge.

Source files
------------

// File: rtl/datapath_exec.sv
// Register-transfer datapath executing one 32-bit CU control word per cycle.
// Holds PC/MAR/MBR/IR/BR/ACC/MR/RES and the ALU, and drives the memory port.
module datapath_exec #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       control_signal,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [7:0]        data_to_cu,
    output logic [7:0]        flags,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] acc_out
);

    localparam int B_MAR2MEM  = 0;
    localparam int B_PC2MBR   = 1;
    localparam int B_PC2MAR   = 2;
    localparam int B_MBR2PC   = 3;
    localparam int B_MBR2IR   = 4;
    localparam int B_MEM2MBR  = 5;
    localparam int B_MBR2BR   = 6;
    localparam int B_MBR2MAR  = 8;
    localparam int B_MBR2ACC  = 10;
    localparam int B_ACC2MBR  = 11;
    localparam int B_MBR2MEM  = 12;
    localparam int B_IR2CU    = 13;
    localparam int B_MR2MBR   = 15;
    localparam int B_ALU2MBR  = 16;
    localparam int B_PC_PLUS1 = 20;
    localparam int B_ACC_CLR  = 21;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mbr_q, mbr_d;
    logic [7:0]        ir_q, ir_d;
    logic [DATA_W-1:0] br_q, br_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mr_q, mr_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [7:0]        dcu_q, dcu_d;
    logic [3:0]        nzcv_q, nzcv_d;
    logic              err_q, err_d;

    logic [31:0] cs;
    logic [9:0]  alu_op;
    logic        alu_multi;
    logic        alu_valid;
    logic [3:0]  shamt;
    logic        unused_cs;

    assign cs        = control_signal;
    assign alu_op    = cs[31:22];
    assign alu_multi = (alu_op & (alu_op - 10'd1)) != 10'd0;
    assign alu_valid = (alu_op != 10'd0) && !alu_multi;
    assign shamt     = br_q[3:0];
    assign unused_cs = ^{cs[7], cs[9], cs[14], cs[19:17]};

    logic [DATA_W:0]            sum_w;
    logic [DATA_W:0]            diff_w;
    logic [DATA_W:0]            shl_w;
    logic [DATA_W:0]            shr_w;
    logic signed [DATA_W:0]     sar_w;
    logic signed [2*DATA_W-1:0] prod_w;
    logic                       asl_v;
    logic [DATA_W-1:0]          alu_res;
    logic [DATA_W-1:0]          alu_hi;
    logic                       alu_c;
    logic                       alu_v;

    // Shifts carry one extra bit so the last bit shifted out lands in it.
    assign sum_w  = {1'b0, acc_q} + {1'b0, br_q};
    assign diff_w = {1'b0, acc_q} - {1'b0, br_q};
    assign shl_w  = {1'b0, acc_q} << shamt;
    assign shr_w  = {acc_q, 1'b0} >> shamt;
    assign sar_w  = $signed({acc_q, 1'b0}) >>> shamt;
    assign prod_w = $signed(acc_q) * $signed(br_q);

    always_comb begin
        asl_v = 1'b0;
        for (int i = 1; i < DATA_W; i++) begin
            if (i <= int'(shamt) && acc_q[DATA_W-1-i] != acc_q[DATA_W-1])
                asl_v = 1'b1;
        end
    end

    always_comb begin
        alu_res = acc_q;
        alu_hi  = mr_q;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        if (alu_valid) begin
            unique case (1'b1)
                alu_op[0]: begin
                    alu_res = sum_w[DATA_W-1:0];
                    alu_c   = sum_w[DATA_W];
                    alu_v   = (acc_q[DATA_W-1] == br_q[DATA_W-1]) &&
                              (sum_w[DATA_W-1] != acc_q[DATA_W-1]);
                end
                alu_op[1]: begin
                    alu_res = diff_w[DATA_W-1:0];
                    alu_c   = ~diff_w[DATA_W];
                    alu_v   = (acc_q[DATA_W-1] != br_q[DATA_W-1]) &&
                              (diff_w[DATA_W-1] != acc_q[DATA_W-1]);
                end
                alu_op[2]: alu_res = acc_q & br_q;
                alu_op[3]: alu_res = acc_q | br_q;
                alu_op[4]: alu_res = ~acc_q;
                alu_op[5]: {alu_c, alu_res} = shl_w;
                alu_op[6]: {alu_res, alu_c} = shr_w;
                alu_op[7]: begin
                    alu_hi  = prod_w[2*DATA_W-1:DATA_W];
                    alu_res = prod_w[DATA_W-1:0];
                    alu_v   = prod_w[2*DATA_W-1:DATA_W] !=
                              {DATA_W{prod_w[DATA_W-1]}};
                end
                alu_op[8]: begin
                    {alu_c, alu_res} = shl_w;
                    alu_v = asl_v;
                end
                alu_op[9]: {alu_res, alu_c} = sar_w;
                default: ;
            endcase
        end
    end

    always_comb begin
        pc_d   = pc_q;
        mar_d  = mar_q;
        mbr_d  = mbr_q;
        ir_d   = ir_q;
        br_d   = br_q;
        acc_d  = acc_q;
        mr_d   = mr_q;
        res_d  = res_q;
        dcu_d  = dcu_q;
        nzcv_d = nzcv_q;
        err_d  = err_q | alu_multi;

        if (cs[B_MEM2MBR])
            mbr_d = mem_rdata;
        else if (cs[B_ALU2MBR])
            mbr_d = res_q;
        else if (cs[B_MR2MBR])
            mbr_d = mr_q;
        else if (cs[B_ACC2MBR])
            mbr_d = acc_q;
        else if (cs[B_PC2MBR])
            mbr_d = {{(DATA_W-ADDR_W){1'b0}}, pc_q};

        if (cs[B_MBR2MAR])
            mar_d = mbr_q[ADDR_W-1:0];
        else if (cs[B_PC2MAR])
            mar_d = pc_q;

        if (cs[B_MBR2PC])
            pc_d = mbr_q[ADDR_W-1:0];
        else if (cs[B_PC_PLUS1])
            pc_d = pc_q + ADDR_W'(1);

        if (cs[B_MBR2IR])
            ir_d = mbr_q[DATA_W-1 -: 8];
        if (cs[B_MBR2BR])
            br_d = mbr_q;
        if (cs[B_IR2CU])
            dcu_d = ir_q;

        // An illegal ALU combination freezes ACC even against clear/load.
        if (alu_multi)
            acc_d = acc_q;
        else if (cs[B_ACC_CLR])
            acc_d = '0;
        else if (alu_valid)
            acc_d = alu_res;
        else if (cs[B_MBR2ACC])
            acc_d = mbr_q;

        if (alu_valid) begin
            res_d  = alu_res;
            mr_d   = alu_hi;
            nzcv_d = {alu_v, alu_c, alu_res[DATA_W-1], alu_res == '0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q   <= PC_RESET;
            mar_q  <= '0;
            mbr_q  <= '0;
            ir_q   <= '0;
            br_q   <= '0;
            acc_q  <= '0;
            mr_q   <= '0;
            res_q  <= '0;
            dcu_q  <= '0;
            nzcv_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            mar_q  <= mar_d;
            mbr_q  <= mbr_d;
            ir_q   <= ir_d;
            br_q   <= br_d;
            acc_q  <= acc_d;
            mr_q   <= mr_d;
            res_q  <= res_d;
            dcu_q  <= dcu_d;
            nzcv_q <= nzcv_d;
            err_q  <= err_d;
        end
    end

    assign mem_addr   = mar_q;
    assign mem_wdata  = mbr_q;
    assign mem_we     = cs[B_MBR2MEM];
    assign mem_re     = cs[B_MAR2MEM] | cs[B_MEM2MBR];
    assign data_to_cu = dcu_q;
    assign flags      = {err_q, 3'b000, nzcv_q};
    assign pc_out     = pc_q;
    assign acc_out    = acc_q;

endmodule

// File: tb/tb_datapath_exec.sv
// Self-checking bench for datapath_exec: directed control words, a
// behavioural register-transfer model and per-cycle output comparison.
module tb_datapath_exec;

    localparam int MAR2MEM = 0;
    localparam int PC2MBR  = 1;
    localparam int PC2MAR  = 2;
    localparam int MBR2PC  = 3;
    localparam int MBR2IR  = 4;
    localparam int MEM2MBR = 5;
    localparam int MBR2BR  = 6;
    localparam int MBR2MAR = 8;
    localparam int MBR2ACC = 10;
    localparam int ACC2MBR = 11;
    localparam int MBR2MEM = 12;
    localparam int IR2CU   = 13;
    localparam int MR2MBR  = 15;
    localparam int ALU2MBR = 16;
    localparam int PCINC   = 20;
    localparam int ACCCLR  = 21;
    localparam int OP_ADD  = 22;
    localparam int OP_SUB  = 23;
    localparam int OP_AND  = 24;
    localparam int OP_OR   = 25;
    localparam int OP_NOT  = 26;
    localparam int OP_LSL  = 27;
    localparam int OP_LSR  = 28;
    localparam int OP_MPY  = 29;
    localparam int OP_ASL  = 30;
    localparam int OP_ASR  = 31;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cs  = '0;
    logic [15:0] mem_rdata;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  data_to_cu;
    logic [7:0]  flags;
    logic [7:0]  pc_out;
    logic [15:0] acc_out;

    datapath_exec dut (
        .clk            (clk),
        .rst            (rst),
        .control_signal (cs),
        .mem_rdata      (mem_rdata),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .mem_re         (mem_re),
        .data_to_cu     (data_to_cu),
        .flags          (flags),
        .pc_out         (pc_out),
        .acc_out        (acc_out)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    assign mem_rdata = mem[mem_addr];

    logic [7:0]  m_pc, m_mar, m_ir, m_dcu;
    logic [15:0] m_mbr, m_br, m_acc, m_mr, m_res;
    logic [3:0]  m_nzcv;
    logic        m_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bit_of(input int n);
        return 32'h1 << n;
    endfunction

    function automatic bit fits16(input int x);
        return x >= -32768 && x <= 32767;
    endfunction

    // Model: plain integer arithmetic on pre-edge values.
    task automatic model_edge(input logic r, input logic [31:0] c);
        logic [15:0] n_mbr, n_acc, r16;
        logic [7:0]  n_mar, n_pc;
        logic [31:0] pv;
        int cnt, op, a, bb, sa, sb, n, t, rr;
        bit cf, vf;
        if (!r) begin
            m_pc = 8'h00; m_mar = '0; m_mbr = '0; m_ir = '0; m_br = '0;
            m_acc = '0; m_mr = '0; m_res = '0; m_dcu = '0;
            m_nzcv = '0; m_err = 1'b0;
            return;
        end
        cnt = 0; op = -1;
        for (int i = 22; i < 32; i++)
            if (c[i]) begin cnt++; op = i; end
        a  = int'(m_acc);
        bb = int'(m_br);
        sa = int'($signed(m_acc));
        sb = int'($signed(m_br));
        n  = int'(m_br[3:0]);
        rr = a; cf = 0; vf = 0;
        n_acc = m_acc;
        if (cnt > 1) begin
            m_err = 1'b1;
        end else if (cnt == 1) begin
            case (op)
                OP_ADD: begin
                    t = a + bb; rr = t; cf = t > 65535; vf = !fits16(sa + sb);
                end
                OP_SUB: begin
                    rr = a - bb; cf = a >= bb; vf = !fits16(sa - sb);
                end
                OP_AND: rr = a & bb;
                OP_OR:  rr = a | bb;
                OP_NOT: rr = ~a;
                OP_LSL: begin
                    rr = a << n; cf = n > 0 && ((a >> (16 - n)) & 1) == 1;
                end
                OP_LSR: begin
                    rr = a >> n; cf = n > 0 && ((a >> (n - 1)) & 1) == 1;
                end
                OP_MPY: begin
                    t = sa * sb; rr = t; pv = t;
                    m_mr = pv[31:16]; vf = !fits16(t);
                end
                OP_ASL: begin
                    rr = a << n; cf = n > 0 && ((a >> (16 - n)) & 1) == 1;
                    vf = !fits16(sa * (1 << n));
                end
                default: begin
                    rr = sa >>> n; cf = n > 0 && ((a >> (n - 1)) & 1) == 1;
                end
            endcase
            r16 = 16'(rr);
            m_res = r16;
            m_nzcv = {vf, cf, r16[15], r16 == 16'h0};
        end
        if (cnt > 1)        n_acc = m_acc;
        else if (c[ACCCLR]) n_acc = 16'h0;
        else if (cnt == 1)  n_acc = m_res;
        else if (c[MBR2ACC]) n_acc = m_mbr;

        n_mbr = c[MEM2MBR] ? mem[m_mar] : c[ALU2MBR] ? m_res_pre(c) :
                c[MR2MBR] ? m_mr_pre : c[ACC2MBR] ? m_acc : c[PC2MBR] ?
                {8'h00, m_pc} : m_mbr;
        n_mar = c[MBR2MAR] ? m_mbr[7:0] : c[PC2MAR] ? m_pc : m_mar;
        n_pc  = c[MBR2PC] ? m_mbr[7:0] : c[PCINC] ? m_pc + 8'd1 : m_pc;
        if (c[IR2CU])  m_dcu = m_ir;
        if (c[MBR2IR]) m_ir = m_mbr[15:8];
        if (c[MBR2BR]) m_br = m_mbr;
        m_mbr = n_mbr;
        m_mar = n_mar;
        m_pc  = n_pc;
        m_acc = n_acc;
    endtask

    // RES/MR as they were before this edge (the ALU above may overwrite them).
    logic [15:0] m_res_old, m_mr_old;
    logic [15:0] m_mr_pre;
    function automatic logic [15:0] m_res_pre(input logic [31:0] c);
        return c[0] ? m_res_old : m_res_old;
    endfunction
    assign m_mr_pre = m_mr_old;

    task automatic step(input logic [31:0] c, input logic r = 1'b1);
        logic       we;
        logic [7:0] wa;
        logic [15:0] wd;
        cs  = c;
        rst = r;
        @(negedge clk);
        we = mem_we; wa = mem_addr; wd = mem_wdata;
        @(posedge clk);
        m_res_old = m_res;
        m_mr_old  = m_mr;
        model_edge(r, c);
        if (we && r) mem[wa] = wd;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("pc_out", pc_out, m_pc);
            chk("acc_out", acc_out, m_acc);
            chk("mem_addr", mem_addr, m_mar);
            chk("mem_wdata", mem_wdata, m_mbr);
            chk("data_to_cu", data_to_cu, m_dcu);
            chk("flags", flags, {m_err, 3'b000, m_nzcv});
            chk("mem_we", mem_we, cs[MBR2MEM]);
            chk("mem_re", mem_re, cs[MAR2MEM] | cs[MEM2MBR]);
        end
    end

    task automatic load_mbr(input logic [15:0] v);
        mem[m_mar] = v;
        step(bit_of(MEM2MBR));
    endtask

    task automatic set_acc(input logic [15:0] v);
        load_mbr(v);
        step(bit_of(MBR2ACC));
    endtask

    task automatic set_br(input logic [15:0] v);
        load_mbr(v);
        step(bit_of(MBR2BR));
    endtask

    localparam int NV = 12;
    logic [15:0] tv_a  [NV] = '{16'h8001, 16'h4000, 16'h2000, 16'hF0F0,
                                16'hF0F0, 16'h1234, 16'h8001, 16'hFFFF,
                                16'h8000, 16'hFFFF, 16'h8000, 16'h1234};
    logic [15:0] tv_b  [NV] = '{16'h0004, 16'h0002, 16'h0001, 16'h0FF0,
                                16'h0FF0, 16'h0000, 16'h0000, 16'h0001,
                                16'h0001, 16'hFFFF, 16'h000F, 16'h0010};
    int          tv_op [NV] = '{OP_LSL, OP_ASL, OP_ASL, OP_AND,
                                OP_OR, OP_NOT, OP_LSL, OP_ADD,
                                OP_SUB, OP_MPY, OP_ASR, OP_LSR};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        m_res_old = '0;
        m_mr_old  = '0;

        step(32'h0, 1'b0);
        step(32'h0, 1'b0);
        chk_on = 1'b1;
        chk("rst_pc", pc_out, 8'h00);
        chk("rst_acc", acc_out, 16'h0000);
        chk("rst_flags", flags, 8'h00);
        chk("rst_dcu", data_to_cu, 8'h00);
        chk("rst_mbr", mem_wdata, 16'h0000);

        // Fetch
        mem[0] = 16'h0305;
        step(bit_of(MEM2MBR));
        chk("fetch_mbr", mem_wdata, 16'h0305);
        step(bit_of(MBR2IR));
        step(bit_of(IR2CU));
        chk("fetch_dcu", data_to_cu, 8'h03);

        // LOAD
        set_acc(16'd5);
        load_mbr(16'h0107);
        mem[7] = 16'h0009;
        step(bit_of(MBR2MAR) | bit_of(PCINC));
        step(bit_of(MEM2MBR));
        step(bit_of(MBR2BR) | bit_of(ACCCLR));
        step(bit_of(OP_ADD));
        chk("load_acc", acc_out, 16'd9);
        chk("load_pc", pc_out, 8'd1);
        chk("load_zn", flags[1:0], 2'b00);

        // Arithmetic edges
        set_acc(16'h7FFF); set_br(16'h0001);
        step(bit_of(OP_ADD));
        chk("add_ovf_acc", acc_out, 16'h8000);
        chk("add_ovf_flags", flags[3:0], 4'b1010);
        set_acc(16'h0003); set_br(16'h0005);
        step(bit_of(OP_SUB));
        chk("sub_acc", acc_out, 16'hFFFE);
        chk("sub_flags", flags[3:0], 4'b0010);
        set_acc(16'h0100); set_br(16'h0100);
        step(bit_of(OP_MPY));
        chk("mpy_acc", acc_out, 16'h0000);
        chk("mpy_flags", flags[3:0], 4'b1001);
        step(bit_of(MR2MBR));
        chk("mpy_mr", mem_wdata, 16'h0001);
        step(bit_of(ALU2MBR));
        chk("mpy_res", mem_wdata, 16'h0000);

        // Shifts
        set_acc(16'h8001); set_br(16'h0001);
        step(bit_of(OP_ASR));
        chk("asr_acc", acc_out, 16'hC000);
        chk("asr_flags", flags[3:0], 4'b0110);
        set_acc(16'h8001);
        step(bit_of(OP_LSR));
        chk("lsr_acc", acc_out, 16'h4000);
        chk("lsr_flags", flags[3:0], 4'b0100);

        // STORE
        set_acc(16'hABCD);
        load_mbr(16'h0010);
        step(bit_of(MBR2MAR));
        step(bit_of(ACC2MBR));
        cs = bit_of(MBR2MEM);
        #1;
        chk("st_we", mem_we, 1'b1);
        chk("st_addr", mem_addr, 8'd16);
        chk("st_wdata", mem_wdata, 16'hABCD);
        step(bit_of(MBR2MEM));
        cs = 32'h0;
        #1;
        chk("st_we_off", mem_we, 1'b0);
        step(32'h0);
        step(bit_of(MEM2MBR));
        chk("st_readback", mem_wdata, 16'hABCD);

        // Collisions
        mem[16] = 16'h1234;
        step(bit_of(MEM2MBR) | bit_of(ACC2MBR));
        chk("mbr_prio", mem_wdata, 16'h1234);
        load_mbr(16'h00FF);
        step(bit_of(MBR2PC));
        chk("pc_ff", pc_out, 8'hFF);
        load_mbr(16'h0020);
        step(bit_of(MBR2PC) | bit_of(PCINC));
        chk("pc_prio", pc_out, 8'h20);
        load_mbr(16'h00FF);
        step(bit_of(MBR2PC));
        step(bit_of(PCINC));
        chk("pc_wrap", pc_out, 8'h00);

        // Illegal ALU combination
        set_acc(16'h1234); set_br(16'h0001);
        step(bit_of(OP_ADD) | bit_of(OP_SUB) | bit_of(MBR2MAR));
        chk("ill_acc", acc_out, 16'h1234);
        chk("ill_err", flags[7], 1'b1);
        chk("ill_mar", mem_addr, 8'h01);
        step(32'h0);
        step(bit_of(OP_ADD));
        chk("ill_sticky", flags, 8'h80);
        chk("ill_after_acc", acc_out, 16'h1235);

        // Reset mid-LOAD
        load_mbr(16'h0107);
        step(bit_of(MBR2MAR) | bit_of(PCINC));
        step(bit_of(MEM2MBR), 1'b0);
        chk("mrst_pc", pc_out, 8'h00);
        chk("mrst_acc", acc_out, 16'h0000);
        chk("mrst_flags", flags, 8'h00);
        chk("mrst_mar", mem_addr, 8'h00);
        chk("mrst_mbr", mem_wdata, 16'h0000);
        step(32'h0);

        for (int k = 0; k < NV; k++) begin
            set_acc(tv_a[k]);
            set_br(tv_b[k]);
            step(bit_of(tv_op[k]));
            step(bit_of(ALU2MBR));
        end
        step(32'h0);
        step(32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
